// File: rtl/smem_bank_scheduler.sv
// rtl/smem_bank_scheduler.sv - warp shared-memory bank conflict scheduler; optional read broadcast under SMEM_BROADCAST_EN
module smem_bank_scheduler #(
    parameter int NUM_LANES     = 8,
    parameter int NUM_BANKS     = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 16,
    localparam int BANK_BITS    = $clog2(NUM_BANKS),
    localparam int ROW_WIDTH    = ADDRESS_WIDTH - BANK_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_write,
    input  logic [NUM_LANES-1:0]                      req_mask,
    input  logic [NUM_LANES-1:0][ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      req_wdata,
    output logic [NUM_BANKS-1:0]                      bank_en,
    output logic                                      bank_we,
    output logic [NUM_BANKS-1:0][ROW_WIDTH-1:0]       bank_addr,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      bank_wdata,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      bank_rdata,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      resp_rdata,
    output logic [3:0]                                pass_count,
    output logic                                      busy
);

    localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                                   state_q, state_d;
    logic                                     write_q, write_d;
    logic [NUM_LANES-1:0]                     pending_q, pending_d;
    logic [NUM_LANES-1:0][ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
    logic [3:0]                               pass_count_q, pass_count_d;
    logic [NUM_LANES-1:0]                     grant_q, grant_d;

    logic [NUM_BANKS-1:0]                     bank_hit;
    logic [LANE_BITS-1:0]                     bank_sel [NUM_BANKS];
    logic [NUM_LANES-1:0]                     granted;

    // Per bank, pick the lowest-index pending lane (descending scan leaves the lowest one selected)
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_hit[b] = 1'b0;
            bank_sel[b] = '0;
            for (int l = NUM_LANES - 1; l >= 0; l--) begin
                if (pending_q[l] && (addr_q[l][BANK_BITS-1:0] == BANK_BITS'(b))) begin
                    bank_hit[b] = 1'b1;
                    bank_sel[b] = LANE_BITS'(l);
                end
            end
        end
    end

    // Lanes serviced this pass: the selected lane, plus same-address readers when broadcast is built in
    always_comb begin
        granted = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
`ifdef SMEM_BROADCAST_EN
            if (pending_q[l] && bank_hit[addr_q[l][BANK_BITS-1:0]]) begin
                if (bank_sel[addr_q[l][BANK_BITS-1:0]] == LANE_BITS'(l)) begin
                    granted[l] = 1'b1;
                end else if (!write_q &&
                             (addr_q[bank_sel[addr_q[l][BANK_BITS-1:0]]] == addr_q[l])) begin
                    granted[l] = 1'b1;
                end
            end
`else
            if (pending_q[l] && bank_hit[addr_q[l][BANK_BITS-1:0]] &&
                (bank_sel[addr_q[l][BANK_BITS-1:0]] == LANE_BITS'(l))) begin
                granted[l] = 1'b1;
            end
`endif
        end
    end

    // Bank array drive: strobes only while issuing, row/data taken from each bank's selected lane
    always_comb begin
        bank_en = (state_q == S_ISSUE) ? bank_hit : '0;
        bank_we = write_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_addr[b]  = '0;
            bank_wdata[b] = '0;
            if (bank_hit[b]) begin
                bank_addr[b]  = addr_q[bank_sel[b]][ADDRESS_WIDTH-1:BANK_BITS];
                bank_wdata[b] = wdata_q[bank_sel[b]];
            end
        end
    end

    // Next-state, request capture, pass accounting and read-return steering
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        pass_count_d = pass_count_q;
        grant_d      = '0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = (state_q != S_IDLE);

        // Data for lanes granted in the previous pass arrives now
        for (int l = 0; l < NUM_LANES; l++) begin
            if (grant_q[l]) begin
                resp_rdata_d[l] = bank_rdata[addr_q[l][BANK_BITS-1:0]];
            end
        end

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d      = req_write;
                    pending_d    = req_mask;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    pass_count_d = 4'd0;
                    resp_rdata_d = '0;
                    state_d      = (req_mask != '0) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                pending_d = pending_q & ~granted;
                if (pass_count_q != 4'hF) begin
                    pass_count_d = pass_count_q + 4'd1;
                end
                // Stores return no data, so only loads are tracked for steering
                grant_d = write_q ? '0 : granted;
                if (pending_d == '0) begin
                    state_d = write_q ? S_RESP : S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            pending_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            pass_count_q <= 4'd0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            pass_count_q <= pass_count_d;
            grant_q      <= grant_d;
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_smem_bank_scheduler.sv
// tb/tb_smem_bank_scheduler.sv - self-checking bench for smem_bank_scheduler
module tb_smem_bank_scheduler;

    localparam int NL = 8;
    localparam int NB = 8;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RW = 5;
    localparam int NR = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   mem_clr = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_write = 1'b0;
    logic [NL-1:0]          req_mask = '0;
    logic [NL-1:0][AW-1:0]  req_addr = '0;
    logic [NL-1:0][DW-1:0]  req_wdata = '0;
    logic [NB-1:0]          bank_en;
    logic                   bank_we;
    logic [NB-1:0][RW-1:0]  bank_addr;
    logic [NB-1:0][DW-1:0]  bank_wdata;
    logic [NB-1:0][DW-1:0]  bank_rdata;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [NL-1:0][DW-1:0]  resp_rdata;
    logic [3:0]             pass_count;
    logic                   busy;

    always #5 clk = ~clk;

    smem_bank_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_mask   (req_mask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .pass_count (pass_count),
        .busy       (busy)
    );

    // Banked scratchpad: unwritten words read as row*16+bank, read data one cycle after bank_en
    logic [DW-1:0] mem_data [NB][NR];
    logic          mem_wr   [NB][NR];

    function automatic logic [DW-1:0] mem_rd(input int b, input int r);
        return mem_wr[b][r] ? mem_data[b][r] : DW'(r * 16 + b);
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int b = 0; b < NB; b++) begin
                bank_rdata[b] <= '0;
                for (int r = 0; r < NR; r++) mem_wr[b][r] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b]) begin
                    if (bank_we) begin
                        mem_data[b][bank_addr[b]] <= bank_wdata[b];
                        mem_wr[b][bank_addr[b]]   <= 1'b1;
                    end else begin
                        bank_rdata[b] <= mem_rd(b, int'(bank_addr[b]));
                    end
                end
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [NB][NR];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Passes = worst bank's service count; loads read the model memory, stores apply in lane order
    task automatic model(input logic wr, input logic [NL-1:0] m, input logic [NL-1:0][AW-1:0] a,
                         input logic [NL-1:0][DW-1:0] wd, output int n,
                         output logic [NL-1:0][DW-1:0] rd, output logic [NB-1:0] bset);
        n = 0;
        rd = '0;
        bset = '0;
        for (int b = 0; b < NB; b++) begin
            int cnt = 0;
            for (int l = 0; l < NL; l++) begin
                if (m[l] && (int'(a[l]) % NB) == b) begin
                    bit dup = 1'b0;
                    bset[b] = 1'b1;
`ifdef SMEM_BROADCAST_EN
                    if (!wr)
                        for (int k = 0; k < l; k++)
                            if (m[k] && a[k] == a[l]) dup = 1'b1;
`endif
                    if (!dup) cnt++;
                end
            end
            if (cnt > n) n = cnt;
        end
        for (int l = 0; l < NL; l++) begin
            if (m[l]) begin
                if (wr) ref_mem[int'(a[l]) % NB][int'(a[l]) / NB] = wd[l];
                else    rd[l] = ref_mem[int'(a[l]) % NB][int'(a[l]) / NB];
            end
        end
    endtask

    // One request end to end; ep/el < 0 means take passes/latency from the model
    task automatic do_req(input string nm, input logic wr, input logic [NL-1:0] m,
                          input logic [NL-1:0][AW-1:0] a, input logic [NL-1:0][DW-1:0] wd,
                          input int hold, input int ep, input int el);
        int n, exp_lat, lat, encyc;
        logic [NL-1:0][DW-1:0] exp_rd, rd;
        logic [NB-1:0] bset, bor;
        logic [3:0] pc;
        bit mem_ok;
        model(wr, m, a, wd, n, exp_rd, bset);
        if (ep >= 0) n = ep;
        exp_lat = (el >= 0) ? el : ((m == '0) ? 1 : (wr ? n + 1 : n + 2));

        @(negedge clk);
        chk({nm, "_req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_mask  = m;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        bor = '0;
        encyc = 0;
        while (!resp_valid && lat < 40) begin
            bor |= bank_en;
            if (bank_en != '0) encyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_resp_seen"}, resp_valid, 1'b1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_passes"}, pass_count, n);
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_bank_set"}, bor, bset);
        chk({nm, "_en_cycles"}, encyc, n);
        rd = resp_rdata;
        pc = pass_count;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold"}, {resp_valid, resp_rdata == rd, pass_count == pc, !req_ready, busy}, 5'h1F);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({nm, "_back_idle"}, {req_ready, busy, resp_valid}, 3'b100);
        if (wr) begin
            mem_ok = 1'b1;
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NR; r++)
                    if (mem_rd(b, r) !== ref_mem[b][r]) mem_ok = 1'b0;
            chk({nm, "_mem"}, mem_ok, 1'b1);
        end
    endtask

    typedef struct {
        logic                  wr;
        logic [NL-1:0]         m;
        logic [NL-1:0][AW-1:0] a;
        logic [NL-1:0][DW-1:0] wd;
        int                    hold;
        int                    passes;
        int                    lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [NL-1:0][AW-1:0] a;
        logic [NL-1:0][DW-1:0] wd;

        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NR; r++)
                ref_mem[b][r] = DW'(r * 16 + b);

        // Directed vectors
        for (int i = 0; i < NL; i++) a[i] = AW'(8 * i + i % 8);
        vecs[0] = '{1'b0, 8'hFF, a, '0, 0, 1, 3};
        for (int i = 0; i < NL; i++) a[i] = AW'(8 * i);
        vecs[1] = '{1'b0, 8'hFF, a, '0, 1, 8, 10};
        for (int i = 0; i < NL; i++) begin
            a[i] = 8'h00;
            wd[i] = 16'hDEAD;
        end
        a[2] = 8'h13; wd[2] = 16'hAAAA;
        a[5] = 8'h13; wd[5] = 16'h5555;
        vecs[2] = '{1'b1, 8'h24, a, wd, 0, 2, 3};
        for (int i = 0; i < NL; i++) a[i] = 8'h21;
`ifdef SMEM_BROADCAST_EN
        vecs[3] = '{1'b0, 8'hFF, a, '0, 0, 1, 3};
`else
        vecs[3] = '{1'b0, 8'hFF, a, '0, 0, 8, 10};
`endif
        for (int i = 0; i < NL; i++) a[i] = AW'($urandom_range(0, 255));
        vecs[4] = '{1'b0, 8'h00, a, '0, 5, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {req_ready, busy, resp_valid, bank_en, pass_count}, {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
        chk("reset_rdata", resp_rdata, '0);
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < 5; i++)
            do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].m, vecs[i].a, vecs[i].wd,
                   vecs[i].hold, vecs[i].passes, vecs[i].lat);
        chk("vec2_bank3_row2", mem_rd(3, 2), 16'h5555);

        // Reset during the 3rd ISSUE cycle of an 8-pass read
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_mask  = 8'hFF;
        for (int i = 0; i < NL; i++) req_addr[i] = AW'(8 * i);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pre_en", {bank_en, busy}, {8'h01, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {bank_en, busy, req_ready, resp_valid, pass_count}, {8'h00, 1'b0, 1'b1, 1'b0, 4'h0});
        chk("rst_mid_rdata", resp_rdata, '0);
        @(negedge clk);
        rst = 1'b0;
        do_req("after_rst", vecs[0].wr, vecs[0].m, vecs[0].a, vecs[0].wd, 0, 1, 3);

        // Randomized requests against the model
        for (int t = 0; t < 40; t++) begin
            logic wr;
            logic [NL-1:0] m;
            wr = 1'($urandom_range(0, 1));
            m = NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                a[i] = (t % 3 == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 31));
                wd[i] = DW'($urandom);
            end
            do_req($sformatf("rnd%0d", t), wr, m, a, wd, $urandom_range(0, 2), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smem_bank_scheduler.md
Name: smem_bank_scheduler

Overview:
- Sequences one warp-wide shared-memory access (8 lanes) onto the banked scratchpad.
- Each cycle ("pass") it grants at most one pending lane per bank, drives the bank array, and collects read data.
- Repeats until every active lane is serviced, then returns one response. Bank conflicts therefore cost extra cycles instead of corrupting data.
- Sits between the lane load/store unit and the per-bank shared memory subunits.

Parameters:
- NUM_LANES, 8, number of requesting threads.
- NUM_BANKS, 8, number of banks; power of 2. BANK_BITS = $clog2(NUM_BANKS).
- ADDRESS_WIDTH, 8, full lane address width. Bank = addr[BANK_BITS-1:0]; row = addr[ADDRESS_WIDTH-1:BANK_BITS].
- DATA_WIDTH, 16, word width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_mask  input  NUM_LANES  active lanes.
- req_addr  input  NUM_LANES x ADDRESS_WIDTH  per-lane address.
- req_wdata  input  NUM_LANES x DATA_WIDTH  per-lane store data.
- bank_en  output  NUM_BANKS  bank access strobe.
- bank_we  output  1  write enable, common to all banks.
- bank_addr  output  NUM_BANKS x (ADDRESS_WIDTH-BANK_BITS)  row per bank.
- bank_wdata  output  NUM_BANKS x DATA_WIDTH  store data per bank.
- bank_rdata  input  NUM_BANKS x DATA_WIDTH  read data, valid 1 cycle after bank_en.
- resp_valid  output  1  response ready.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  NUM_LANES x DATA_WIDTH  per-lane load data; 0 for inactive lanes and for stores.
- pass_count  output  4  passes used by the last request.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state): state = IDLE.
  - pending, resp_rdata, pass_count, bank_en, resp_valid = 0.
  - req_ready = 1, busy = 0.
  - An in-flight request is discarded; no response is produced.
- States are IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_valid && req_ready latches write, mask, addr and wdata; pending = req_mask; pass_count = 0; resp_rdata is cleared.
  - Next state is ISSUE if mask != 0, else RESP.
- ISSUE, each cycle:
  - For each bank b, grant the lowest-index pending lane whose bank equals b.
  - bank_en[b] = 1; bank_addr[b] and bank_wdata[b] come from that lane; bank_we = latched write.
  - Granted lanes are cleared from pending; pass_count += 1 (saturates at 15).
  - Grant map (lane to bank, valid) is registered for read-return steering.
- Read return:
  - In the cycle after any ISSUE cycle, bank_rdata[bank] is written to resp_rdata[lane] for each lane in the registered grant map.
- ISSUE exit (pending becomes 0 this cycle):
  - Read: go to DRAIN, which captures the final pass's data for one cycle, then RESP.
  - Write: go directly to RESP.
- bank_en is combinational from state and pending; it is 0 outside ISSUE.
- RESP:
  - resp_valid = 1, held until resp_ready; then IDLE.
  - resp_rdata and pass_count stay stable while resp_valid is high.
  - req_ready = 0 until back in IDLE.
- Latency, from the accept edge to the first resp_valid cycle:
  - Reads: N+2 cycles.
  - Writes: N+1 cycles.
  - N = maximum number of active lanes mapping to any one bank.
- Same-address writes from several lanes are serialized in ascending lane order, so the highest lane's data is what remains stored.
- Inactive lanes never generate bank_en.

Optional Feature:
- Macro SMEM_BROADCAST_EN.
- Defined: in ISSUE for a read, all pending lanes whose full address equals the granted lane's address are granted in the same pass and receive the same bank_rdata. Writes are unchanged.
- Undefined: strictly one lane per bank per pass. Identical read addresses serialize.

Test Plan:
- Read, mask 0xFF, addr lane i = 8*i+i%8 (all banks distinct), bank model returns row*16+bank → pass_count=1, resp_valid 3 cycles after accept, each lane gets its value.
- Read, mask 0xFF, addr lane i = 8*i (all bank 0) → 8 passes, resp_valid 10 cycles after accept, bank_en only ever 0x01.
- Write, mask 0x24, lane2 and lane5 both to addr 0x13, data 0xAAAA / 0x5555 → 2 passes, bank 3 row 2 ends at 0x5555.
- Read, mask 0xFF, all lanes to addr 0x21 → with SMEM_BROADCAST_EN: pass_count=1, every lane receives the same word; without: pass_count=8.
- Mask 0x00 read → RESP the cycle after accept, pass_count=0, resp_rdata all 0, no bank_en. Then hold resp_ready=0 for 5 cycles → resp_valid and data stable; req_ready=0 throughout.
- Assert rst during the 3rd ISSUE cycle of an 8-pass read → bank_en=0, busy=0, req_ready=1 immediately. Next request completes normally with pass_count from the new request only.
